// File: rtl/vuart_pkg.sv
// Shared definitions for the vUART 16550 register block.
// Holds the register index map (urt_addr[4:2]), the IIR interrupt codes
// and the mapping from FCR[7:6] to the RX trigger level.
package vuart_pkg;

    localparam logic [2:0] RBR_THR = 3'd0;
    localparam logic [2:0] IER_DLM = 3'd1;
    localparam logic [2:0] IIR_FCR = 3'd2;
    localparam logic [2:0] LCR     = 3'd3;
    localparam logic [2:0] MCR     = 3'd4;
    localparam logic [2:0] LSR     = 3'd5;
    localparam logic [2:0] MSR     = 3'd6;
    localparam logic [2:0] SCR     = 3'd7;

    localparam logic [3:0] IIR_LS   = 4'h6;
    localparam logic [3:0] IIR_RDA  = 4'h4;
    localparam logic [3:0] IIR_THRE = 4'h2;
    localparam logic [3:0] IIR_NONE = 4'h1;

    // RX FIFO fill level at which the data-available interrupt fires.
    function automatic logic [4:0] rx_trigger_level(input logic [1:0] sel);
        logic [4:0] lvl;
        case (sel)
            2'b00:   lvl = 5'd1;
            2'b01:   lvl = 5'd4;
            2'b10:   lvl = 5'd8;
            default: lvl = 5'd14;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/vuart_16550_regs_if.sv
// CSR strobe bus between the vUART decode stage (master) and the 16550
// register block (slave).
//   urt_addr      : byte address, register index in [4:2]
//   urt_write     : one-cycle write strobe, data in urt_writedata[7:0]
//   urt_read      : one-cycle read strobe
//   urt_readdata  : registered read data, valid the cycle after urt_read
interface vuart_16550_regs_if #(
    parameter int unsigned ADDR_WIDTH = 9
);
    logic [ADDR_WIDTH-1:0] urt_addr;
    logic                  urt_write;
    logic [31:0]           urt_writedata;
    logic                  urt_read;
    logic [31:0]           urt_readdata;

    modport master (
        output urt_addr,
        output urt_write,
        output urt_writedata,
        output urt_read,
        input  urt_readdata
    );

    modport slave (
        input  urt_addr,
        input  urt_write,
        input  urt_writedata,
        input  urt_read,
        output urt_readdata
    );
endinterface

// File: rtl/vuart_sync_fifo.sv
// Single-clock show-ahead FIFO used for the vUART TX and RX byte queues.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous flush, overrides push and pop
//   push     : write wdata; accepted when not full, or when full and a pop
//              happens in the same cycle
//   pop      : drop the head entry (ignored when empty)
//   rdata    : current head entry
//   count    : number of stored entries, log2(DEPTH)+1 bits
//   full, empty : occupancy flags
module vuart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign pop_ok  = pop & ~empty;
    // A full FIFO still takes a push if the head leaves in the same cycle.
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_ok && !pop_ok) count_d = count_q + 1'b1;
            if (pop_ok && !push_ok) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok && !clr) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/vuart_16550_regs.sv
// 16550-compatible register file with TX/RX byte FIFOs for the virtual UART.
//   clk_50m, rst_50m : clock, asynchronous active-high reset
//   bus              : CSR strobe bus (slave side), registered read data
//   tx_data/tx_valid : show-ahead head of the TX FIFO, popped on tx_ready
//   tx_busy          : serial shifter active, folds into LSR.TEMT
//   rx_data/rx_valid : received byte push strobe, no backpressure
//   baud_div         : {DLM, DLL}
//   lcr, mcr         : line and modem control registers
//   irq              : registered interrupt request
module vuart_16550_regs
    import vuart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ADDR_WIDTH = 9
) (
    input  logic                     clk_50m,
    input  logic                     rst_50m,
    vuart_16550_regs_if.slave        bus,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    input  logic                     tx_busy,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic [15:0]              baud_div,
    output logic [7:0]               lcr,
    output logic [4:0]               mcr,
    output logic                     irq
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [2:0]       reg_idx;
    logic             addr_ok, dlab, rd_en, wr_en;
    logic [7:0]       wbyte;
    logic             thr_wr, rbr_rd, fcr_wr, tx_clr, rx_clr, tx_pop;
    logic [7:0]       tx_head, rx_head;
    logic [CNT_W-1:0] tx_count, rx_count;
    logic             tx_full, tx_empty, rx_full, rx_empty;
    logic             tx_goes_empty, rx_overrun, thre_arm;
    logic [3:0]       iir_code;
    logic [7:0]       lsr_val, rd_byte;
    logic             unused_bits;

    logic [7:0]  dll_q, dll_d, dlm_q, dlm_d, lcr_q, lcr_d, scr_q, scr_d;
    logic [4:0]  mcr_q, mcr_d;
    logic [3:0]  ier_q, ier_d;
    logic        fcr0_q, fcr0_d;
    logic [1:0]  fcr_trig_q, fcr_trig_d;
    logic        oe_q, oe_d, thre_pend_q, thre_pend_d, irq_q, irq_d;
    logic [31:0] readdata_q, readdata_d;

    assign reg_idx = bus.urt_addr[4:2];
    assign addr_ok = ~|bus.urt_addr[ADDR_WIDTH-1:5];
    assign dlab    = lcr_q[7];
    assign wbyte   = bus.urt_writedata[7:0];
    assign rd_en   = bus.urt_read & addr_ok;
    // A write colliding with a read is dropped.
    assign wr_en   = bus.urt_write & ~bus.urt_read & addr_ok;

    assign thr_wr  = wr_en & (reg_idx == RBR_THR) & ~dlab;
    assign rbr_rd  = rd_en & (reg_idx == RBR_THR) & ~dlab;
    assign fcr_wr  = wr_en & (reg_idx == IIR_FCR);
    assign tx_clr  = fcr_wr & wbyte[2];
    assign rx_clr  = fcr_wr & wbyte[1];
    assign tx_pop  = tx_valid & tx_ready;

    vuart_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk_50m),
        .rst   (rst_50m),
        .clr   (tx_clr),
        .push  (thr_wr),
        .wdata (wbyte),
        .pop   (tx_pop),
        .rdata (tx_head),
        .count (tx_count),
        .full  (tx_full),
        .empty (tx_empty)
    );

    vuart_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk   (clk_50m),
        .rst   (rst_50m),
        .clr   (rx_clr),
        .push  (rx_valid),
        .wdata (rx_data),
        .pop   (rbr_rd),
        .rdata (rx_head),
        .count (rx_count),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // Last byte leaves without a refill (a same-cycle THR write keeps it at 1),
    // or a flush empties a non-empty FIFO.
    assign tx_goes_empty = (tx_clr & ~tx_empty) |
                           (~tx_clr & tx_pop & ~thr_wr & (tx_count == CNT_W'(1)));
    assign rx_overrun    = rx_valid & rx_full & ~rbr_rd & ~rx_clr;
    assign thre_arm      = wr_en & (reg_idx == IER_DLM) & ~dlab & wbyte[1] & tx_empty;

    always_comb begin
        iir_code = IIR_NONE;
        if (ier_q[2] && oe_q) begin
            iir_code = IIR_LS;
        end else if (ier_q[0] && (rx_count >= CNT_W'(rx_trigger_level(fcr_trig_q)))) begin
            iir_code = IIR_RDA;
        end else if (ier_q[1] && thre_pend_q) begin
            iir_code = IIR_THRE;
        end
    end

    assign lsr_val = {1'b0, tx_empty & ~tx_busy, tx_empty, 3'b000, oe_q, ~rx_empty};

    always_comb begin
        rd_byte = 8'h00;
        case (reg_idx)
            RBR_THR: rd_byte = dlab ? dll_q : (rx_empty ? 8'h00 : rx_head);
            IER_DLM: rd_byte = dlab ? dlm_q : {4'h0, ier_q};
            IIR_FCR: rd_byte = {fcr0_q, fcr0_q, 2'b00, iir_code};
            LCR:     rd_byte = lcr_q;
            MCR:     rd_byte = {3'b000, mcr_q};
            LSR:     rd_byte = lsr_val;
            MSR:     rd_byte = 8'h00;
            default: rd_byte = scr_q;
        endcase
    end

    always_comb begin
        dll_d       = dll_q;
        dlm_d       = dlm_q;
        lcr_d       = lcr_q;
        scr_d       = scr_q;
        mcr_d       = mcr_q;
        ier_d       = ier_q;
        fcr0_d      = fcr0_q;
        fcr_trig_d  = fcr_trig_q;
        oe_d        = oe_q;
        thre_pend_d = thre_pend_q;
        readdata_d  = readdata_q;
        irq_d       = (iir_code != IIR_NONE);

        if (wr_en) begin
            case (reg_idx)
                RBR_THR: if (dlab) dll_d = wbyte;
                IER_DLM: begin
                    if (dlab) dlm_d = wbyte;
                    else      ier_d = wbyte[3:0];
                end
                IIR_FCR: begin
                    fcr0_d     = wbyte[0];
                    fcr_trig_d = wbyte[7:6];
                end
                LCR:     lcr_d = wbyte;
                MCR:     mcr_d = wbyte[4:0];
                SCR:     scr_d = wbyte;
                default: ;
            endcase
        end

        // A new overrun wins over the LSR read that would clear it.
        if (rx_overrun) begin
            oe_d = 1'b1;
        end else if (rd_en && (reg_idx == LSR)) begin
            oe_d = 1'b0;
        end

        if (tx_goes_empty || thre_arm) begin
            thre_pend_d = 1'b1;
        end else if (thr_wr || (rd_en && (reg_idx == IIR_FCR) && (iir_code == IIR_THRE))) begin
            thre_pend_d = 1'b0;
        end

        if (bus.urt_read) readdata_d = addr_ok ? {24'h0, rd_byte} : 32'h0;
    end

    always_ff @(posedge clk_50m or posedge rst_50m) begin
        if (rst_50m) begin
            dll_q       <= 8'h01;
            dlm_q       <= 8'h00;
            lcr_q       <= 8'h00;
            scr_q       <= 8'h00;
            mcr_q       <= 5'h00;
            ier_q       <= 4'h0;
            fcr0_q      <= 1'b0;
            fcr_trig_q  <= 2'b00;
            oe_q        <= 1'b0;
            thre_pend_q <= 1'b0;
            irq_q       <= 1'b0;
            readdata_q  <= 32'h0;
        end else begin
            dll_q       <= dll_d;
            dlm_q       <= dlm_d;
            lcr_q       <= lcr_d;
            scr_q       <= scr_d;
            mcr_q       <= mcr_d;
            ier_q       <= ier_d;
            fcr0_q      <= fcr0_d;
            fcr_trig_q  <= fcr_trig_d;
            oe_q        <= oe_d;
            thre_pend_q <= thre_pend_d;
            irq_q       <= irq_d;
            readdata_q  <= readdata_d;
        end
    end

    assign bus.urt_readdata = readdata_q;
    assign tx_data          = tx_head;
    assign tx_valid         = ~tx_empty;
    assign baud_div         = {dlm_q, dll_q};
    assign lcr              = lcr_q;
    assign mcr              = mcr_q;
    assign irq              = irq_q;

    assign unused_bits = ^{bus.urt_writedata[31:8], bus.urt_addr[1:0], tx_full};

endmodule

// File: tb/tb_vuart_16550_regs.sv
// Randomized and directed bench for vuart_16550_regs against a queue-based
// reference model of the 16550 register behaviour.
module tb_vuart_16550_regs;

    localparam int unsigned DEPTH = 16;

    logic       clk_50m = 1'b0;
    logic       rst_50m = 1'b1;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic       tx_busy  = 1'b0;
    logic [7:0] rx_data  = 8'h00;
    logic       rx_valid = 1'b0;
    logic [15:0] baud_div;
    logic [7:0] lcr;
    logic [4:0] mcr;
    logic       irq;

    vuart_16550_regs_if #(.ADDR_WIDTH(9)) bus ();

    vuart_16550_regs #(
        .FIFO_DEPTH (DEPTH),
        .ADDR_WIDTH (9)
    ) dut (
        .clk_50m  (clk_50m),
        .rst_50m  (rst_50m),
        .bus      (bus),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_busy  (tx_busy),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .baud_div (baud_div),
        .lcr      (lcr),
        .mcr      (mcr),
        .irq      (irq)
    );

    always #10 clk_50m = ~clk_50m;

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];
    logic [7:0]  m_dll, m_dlm, m_lcr, m_scr;
    logic [4:0]  m_mcr;
    logic [3:0]  m_ier;
    logic        m_fcr0, m_oe, m_pend, m_irq;
    logic [1:0]  m_trig;
    logic [31:0] m_rdata;

    task automatic model_reset();
        tx_q.delete();
        rx_q.delete();
        m_dll = 8'h01; m_dlm = 8'h00; m_lcr = 8'h00; m_scr = 8'h00;
        m_mcr = 5'h00; m_ier = 4'h0; m_fcr0 = 1'b0; m_trig = 2'b00;
        m_oe = 1'b0; m_pend = 1'b0; m_irq = 1'b0; m_rdata = 32'h0;
    endtask

    function automatic int trig_of(input logic [1:0] s);
        case (s)
            2'd0: return 1;
            2'd1: return 4;
            2'd2: return 8;
            default: return 14;
        endcase
    endfunction

    function automatic logic [3:0] m_code();
        if (m_ier[2] && m_oe) return 4'h6;
        if (m_ier[0] && (rx_q.size() >= trig_of(m_trig))) return 4'h4;
        if (m_ier[1] && m_pend) return 4'h2;
        return 4'h1;
    endfunction

    function automatic logic [7:0] m_readback(input logic [2:0] idx, input logic busy,
                                              input logic [3:0] code);
        logic dl;
        logic tx_e;
        dl   = m_lcr[7];
        tx_e = (tx_q.size() == 0);
        case (idx)
            3'd0: return dl ? m_dll : ((rx_q.size() > 0) ? rx_q[0] : 8'h00);
            3'd1: return dl ? m_dlm : {4'h0, m_ier};
            3'd2: return {m_fcr0, m_fcr0, 2'b00, code};
            3'd3: return m_lcr;
            3'd4: return {3'b000, m_mcr};
            3'd5: return {1'b0, tx_e && !busy, tx_e, 3'b000, m_oe, rx_q.size() > 0};
            3'd6: return 8'h00;
            default: return m_scr;
        endcase
    endfunction

    task automatic model_step(input logic rd, input logic wr, input logic [8:0] addr,
                              input logic [7:0] wd, input logic rxv, input logic [7:0] rxb,
                              input logic txr, input logic busy);
        logic       ok, w, r, dl, thr_w, rbr_r, fcr_w, popped, became_empty, overrun;
        logic [2:0] idx;
        logic [3:0] code;
        int         tx_n, rx_n;
        ok    = (addr[8:5] == 4'h0);
        idx   = addr[4:2];
        dl    = m_lcr[7];
        w     = wr && !rd && ok;
        r     = rd && ok;
        code  = m_code();
        thr_w = w && idx == 3'd0 && !dl;
        rbr_r = r && idx == 3'd0 && !dl;
        fcr_w = w && idx == 3'd2;
        tx_n  = tx_q.size();
        rx_n  = rx_q.size();
        if (rd) m_rdata = ok ? {24'h0, m_readback(idx, busy, code)} : 32'h0;

        became_empty = 1'b0;
        if (fcr_w && wd[2]) begin
            became_empty = (tx_n > 0);
            tx_q.delete();
        end else begin
            popped = txr && tx_n > 0;
            if (popped) void'(tx_q.pop_front());
            if (thr_w && (tx_n < DEPTH || popped)) tx_q.push_back(wd);
            became_empty = (tx_n > 0) && (tx_q.size() == 0);
        end

        overrun = 1'b0;
        if (fcr_w && wd[1]) begin
            rx_q.delete();
        end else begin
            popped = rbr_r && rx_n > 0;
            if (popped) void'(rx_q.pop_front());
            if (rxv) begin
                if (rx_n < DEPTH || popped) rx_q.push_back(rxb);
                else overrun = 1'b1;
            end
        end

        if (overrun) m_oe = 1'b1;
        else if (r && idx == 3'd5) m_oe = 1'b0;

        if (became_empty || (w && idx == 3'd1 && !dl && wd[1] && tx_n == 0)) m_pend = 1'b1;
        else if (thr_w || (r && idx == 3'd2 && code == 4'h2)) m_pend = 1'b0;

        if (w) begin
            case (idx)
                3'd0: if (dl) m_dll = wd;
                3'd1: if (dl) m_dlm = wd; else m_ier = wd[3:0];
                3'd2: begin m_fcr0 = wd[0]; m_trig = wd[7:6]; end
                3'd3: m_lcr = wd;
                3'd4: m_mcr = wd[4:0];
                3'd7: m_scr = wd;
                default: ;
            endcase
        end
        m_irq = (code != 4'h1);
    endtask

    task automatic check_outputs();
        check_eq("rdata", bus.urt_readdata, m_rdata);
        check_eq("irq", 32'(irq), 32'(m_irq));
        check_eq("tx_valid", 32'(tx_valid), 32'(tx_q.size() > 0));
        if (tx_q.size() > 0) check_eq("tx_data", 32'(tx_data), 32'(tx_q[0]));
        check_eq("baud_div", 32'(baud_div), {16'h0, m_dlm, m_dll});
        check_eq("lcr", 32'(lcr), 32'(m_lcr));
        check_eq("mcr", 32'(mcr), 32'(m_mcr));
    endtask

    // ---------------- stimulus helpers ----------------
    logic g_txr  = 1'b0;
    logic g_busy = 1'b0;

    task automatic cyc(input logic rd, input logic wr, input logic [8:0] addr,
                       input logic [7:0] wd, input logic rxv, input logic [7:0] rxb,
                       input logic txr, input logic busy);
        bus.urt_read      = rd;
        bus.urt_write     = wr;
        bus.urt_addr      = addr;
        bus.urt_writedata = {24'($urandom()), wd};
        rx_valid          = rxv;
        rx_data           = rxb;
        tx_ready          = txr;
        tx_busy           = busy;
        @(posedge clk_50m);
        model_step(rd, wr, addr, wd, rxv, rxb, txr, busy);
        #1;
        check_outputs();
        bus.urt_read  = 1'b0;
        bus.urt_write = 1'b0;
        rx_valid      = 1'b0;
    endtask

    task automatic wr_reg(input logic [2:0] idx, input logic [7:0] d);
        cyc(1'b0, 1'b1, {4'h0, idx, 2'b00}, d, 1'b0, 8'h00, g_txr, g_busy);
    endtask

    task automatic rd_reg(input logic [2:0] idx);
        cyc(1'b1, 1'b0, {4'h0, idx, 2'b00}, 8'h00, 1'b0, 8'h00, g_txr, g_busy);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 9'h0, 8'h00, 1'b0, 8'h00, g_txr, g_busy);
    endtask

    task automatic push_rx(input logic [7:0] b);
        cyc(1'b0, 1'b0, 9'h0, 8'h00, 1'b1, b, g_txr, g_busy);
    endtask

    task automatic do_reset();
        bus.urt_read      = 1'b0;
        bus.urt_write     = 1'b0;
        bus.urt_addr      = 9'h0;
        bus.urt_writedata = 32'h0;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        tx_busy  = 1'b0;
        g_txr    = 1'b0;
        g_busy   = 1'b0;
        rst_50m  = 1'b1;
        model_reset();
        repeat (2) @(posedge clk_50m);
        #1;
        rst_50m = 1'b0;
        check_outputs();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bus.urt_read      = 1'b0;
        bus.urt_write     = 1'b0;
        bus.urt_addr      = 9'h0;
        bus.urt_writedata = 32'h0;

        // Reset defaults
        do_reset();
        check_eq("rst_baud", 32'(baud_div), 32'h0001);
        check_eq("rst_irq", 32'(irq), 32'h0);
        check_eq("rst_txv", 32'(tx_valid), 32'h0);
        check_eq("rst_rdata", bus.urt_readdata, 32'h0);
        rd_reg(3'd3); check_eq("rst_lcr", bus.urt_readdata, 32'h00);
        rd_reg(3'd5); check_eq("rst_lsr", bus.urt_readdata, 32'h60);
        rd_reg(3'd2); check_eq("rst_iir", bus.urt_readdata, 32'h01);
        wr_reg(3'd3, 8'h80);
        rd_reg(3'd0); check_eq("rst_dll", bus.urt_readdata, 32'h01);

        // TX overflow: 17th byte is lost
        do_reset();
        for (int i = 0; i <= 16; i++) wr_reg(3'd0, 8'(i));
        g_txr = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check_eq("tx_seq", 32'(tx_data), 32'(i));
            idle(1);
        end
        check_eq("tx_drained", 32'(tx_valid), 32'h0);

        // RX overrun
        do_reset();
        wr_reg(3'd2, 8'h01);
        wr_reg(3'd1, 8'h05);
        for (int i = 0; i <= 16; i++) push_rx(8'(8'h40 + i));
        idle(1);
        rd_reg(3'd2); check_eq("ovr_iir", bus.urt_readdata, 32'hC6);
        check_eq("ovr_irq", 32'(irq), 32'h1);
        rd_reg(3'd5); check_eq("ovr_lsr", bus.urt_readdata, 32'h63);
        rd_reg(3'd2); check_eq("ovr_iir2", bus.urt_readdata, 32'hC4);
        rd_reg(3'd5); check_eq("ovr_lsr2", bus.urt_readdata, 32'h61);

        // RX trigger level 8
        do_reset();
        wr_reg(3'd1, 8'h01);
        wr_reg(3'd2, 8'h81);
        for (int i = 0; i < 7; i++) push_rx(8'(i));
        idle(1);
        check_eq("trig7_irq", 32'(irq), 32'h0);
        push_rx(8'h07);
        check_eq("trig8_lag", 32'(irq), 32'h0);
        idle(1);
        check_eq("trig8_irq", 32'(irq), 32'h1);
        rd_reg(3'd2); check_eq("trig_iir", bus.urt_readdata, 32'hC4);
        rd_reg(3'd0); check_eq("trig_rbr", bus.urt_readdata, 32'h00);
        idle(1);
        check_eq("trig_drop", 32'(irq), 32'h0);

        // THRE interrupt
        do_reset();
        wr_reg(3'd2, 8'h01);
        wr_reg(3'd1, 8'h02);
        idle(1);
        check_eq("thre_irq", 32'(irq), 32'h1);
        rd_reg(3'd2); check_eq("thre_iir", bus.urt_readdata, 32'hC2);
        rd_reg(3'd2); check_eq("thre_iir2", bus.urt_readdata, 32'hC1);
        check_eq("thre_irq_off", 32'(irq), 32'h0);
        wr_reg(3'd0, 8'h33);
        g_txr = 1'b1;
        idle(1);
        g_txr = 1'b0;
        idle(1);
        check_eq("thre_rearm", 32'(irq), 32'h1);

        // Simultaneous push and pop on a full RX FIFO
        do_reset();
        for (int i = 0; i < 16; i++) push_rx(8'(8'hA0 + i));
        cyc(1'b1, 1'b0, 9'h0, 8'h00, 1'b1, 8'h55, 1'b0, 1'b0);
        check_eq("sim_rbr", bus.urt_readdata, 32'hA0);
        rd_reg(3'd5); check_eq("sim_lsr", bus.urt_readdata, 32'h61);
        for (int i = 1; i < 16; i++) begin
            rd_reg(3'd0); check_eq("sim_drain", bus.urt_readdata, 32'(8'hA0 + i));
        end
        rd_reg(3'd0); check_eq("sim_last", bus.urt_readdata, 32'h55);
        rd_reg(3'd5); check_eq("sim_empty", bus.urt_readdata, 32'h60);

        // FCR flush during a push
        wr_reg(3'd0, 8'h11);
        wr_reg(3'd0, 8'h22);
        for (int i = 0; i < 3; i++) push_rx(8'(i));
        cyc(1'b0, 1'b1, {4'h0, 3'd2, 2'b00}, 8'h06, 1'b1, 8'h99, 1'b0, 1'b0);
        check_eq("flush_txv", 32'(tx_valid), 32'h0);
        rd_reg(3'd5); check_eq("flush_lsr", bus.urt_readdata, 32'h60);
        rd_reg(3'd0); check_eq("flush_rbr", bus.urt_readdata, 32'h00);

        // Random traffic against the model
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            logic       rd, wr, rxv, txr, busy;
            logic [2:0] idx;
            logic [7:0] wd;
            logic [8:0] addr;
            int         sel;
            sel  = int'($urandom_range(0, 99));
            rd   = 1'b0;
            wr   = 1'b0;
            idx  = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom());
            wd   = 8'($urandom());
            if (idx == 3'd2 && $urandom_range(0, 3) != 0) wd[2:1] = 2'b00;
            if (sel < 35) rd = 1'b1;
            else if (sel < 75) wr = 1'b1;
            else if (sel < 77) begin rd = 1'b1; wr = 1'b1; end
            addr = {4'h0, idx, 2'($urandom())};
            if ($urandom_range(0, 19) == 0) addr[8:5] = 4'($urandom_range(1, 15));
            rxv  = ($urandom_range(0, 99) < 40);
            txr  = ($urandom_range(0, 99) < 30);
            busy = ($urandom_range(0, 3) == 0);
            cyc(rd, wr, addr, wd, rxv, 8'($urandom()), txr, busy);
            if (n == 2000) do_reset();
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
